text_overlay_writer: RTL and testbench

- Parametrised successor to the single-character ROM writer: holds an editable string of NUM_CHARS glyph codes and renders the whole string as a 24-bit pixel stream.
- Glyph bitmaps come from an external font ROM with configurable read latency.
- Two raw active-low pushbuttons edit the string: one cycles the code, one commits it.
- A start pulse renders GLYPH_H rows × (NUM_CHARS·GLYPH_W) pixels through a valid/ready handshake toward the HDMI overlay path.

---
 rtl/text_overlay_writer.sv | 204 ++++++++++++++++++++
 tb/tb_text_overlay_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_overlay_writer.sv
// Editable NUM_CHARS-glyph string rendered from an external font ROM as a 24-bit
// valid/ready pixel stream; two debounced pushbuttons cycle and commit glyph codes.

module text_overlay_key #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       r_sync;
    logic             r_prev;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_key;
    logic             w_accept;

    assign w_key    = r_sync[1];
    assign w_accept = (w_key == r_prev) && (r_cnt == '0) && (w_key != r_level);
    assign o_press  = w_accept && !w_key;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
            r_prev <= w_key;
            // any level change restarts the stability window
            if (w_key != r_prev)
                r_cnt <= CNT_W'(DEBOUNCE_CYCLES - 1);
            else if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
            if (w_accept)
                r_level <= w_key;
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for start
// FETCH | present {code,row} to the font ROM
// WAIT  | ROM_LATENCY cycles until glyph row is latched
// EMIT  | shift out GLYPH_W pixels under valid/ready
// DONE  | frame complete, drop busy
module text_overlay_writer #(
    parameter int                 NUM_CHARS       = 8,
    parameter int                 GLYPH_W         = 8,
    parameter int                 GLYPH_H         = 16,
    parameter int                 CODE_W          = 8,
    parameter int                 ROM_LATENCY     = 1,
    parameter logic [CODE_W-1:0]  CODE_MIN        = 8'h20,
    parameter logic [CODE_W-1:0]  CODE_MAX        = 8'h7E,
    parameter int                 DEBOUNCE_CYCLES = 16,
    parameter logic [23:0]        FG_COLOR        = 24'hFFFFFF,
    parameter logic [23:0]        BG_COLOR        = 24'h000000,
    localparam int                ROW_W           = $clog2(GLYPH_H),
    localparam int                COL_W           = $clog2(NUM_CHARS)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_key_next_n,
    input  logic                    i_key_sel_n,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic [CODE_W+ROW_W-1:0] o_rom_addr,
    input  logic [GLYPH_W-1:0]      i_rom_data,
    output logic [23:0]             o_pix_data,
    output logic                    o_pix_valid,
    input  logic                    i_pix_ready,
    output logic                    o_pix_eol,
    output logic                    o_pix_last,
    output logic [COL_W-1:0]        o_cursor,
    output logic [CODE_W-1:0]       o_cur_code,
    output logic                    o_edit_wrap
);
    localparam int BIT_W  = $clog2(GLYPH_W);
    localparam int WAIT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t                    r_state, w_state_nxt;
    logic [CODE_W-1:0]         r_buf [NUM_CHARS];
    logic [COL_W-1:0]          r_cursor;
    logic [CODE_W-1:0]         r_cur_code;
    logic                      r_edit_wrap;
    logic [ROW_W-1:0]          r_row;
    logic [COL_W-1:0]          r_col;
    logic [BIT_W-1:0]          r_bit;
    logic [WAIT_W-1:0]         r_wait;
    logic [GLYPH_W-1:0]        r_shift;
    logic [CODE_W+ROW_W-1:0]   r_rom_addr;
    logic                      w_next_press, w_sel_press;
    logic                      w_accept, w_bit_last, w_col_last, w_row_last;
    logic [CODE_W+ROW_W-1:0]   w_fetch_addr;

    text_overlay_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .i_clock(i_clock), .i_reset(i_reset), .i_key_n(i_key_next_n), .o_press(w_next_press));
    text_overlay_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sel (
        .i_clock(i_clock), .i_reset(i_reset), .i_key_n(i_key_sel_n), .o_press(w_sel_press));

    // a same-cycle next+sel writes the old code because both use non-blocking updates
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CHARS; i++) r_buf[i] <= CODE_MIN;
            r_cursor    <= '0;
            r_cur_code  <= CODE_MIN;
            r_edit_wrap <= 1'b0;
        end else begin
            r_edit_wrap <= 1'b0;
            if (w_sel_press) begin
                r_buf[r_cursor] <= r_cur_code;
                if (r_cursor == COL_W'(NUM_CHARS - 1)) begin
                    r_cursor    <= '0;
                    r_edit_wrap <= 1'b1;
                end else begin
                    r_cursor <= r_cursor + COL_W'(1);
                end
            end
            if (w_next_press)
                r_cur_code <= (r_cur_code == CODE_MAX) ? CODE_MIN : r_cur_code + CODE_W'(1);
        end
    end

    assign w_accept     = (r_state == S_EMIT) && i_pix_ready;
    assign w_bit_last   = (r_bit == BIT_W'(GLYPH_W - 1));
    assign w_col_last   = (r_col == COL_W'(NUM_CHARS - 1));
    assign w_row_last   = (r_row == ROW_W'(GLYPH_H - 1));
    assign w_fetch_addr = {r_buf[r_col], r_row};

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = (r_state != S_IDLE);
        o_pix_valid = (r_state == S_EMIT);
        o_pix_data  = (o_pix_valid && r_shift[GLYPH_W-1]) ? FG_COLOR : BG_COLOR;
        o_pix_eol   = o_pix_valid && w_bit_last && w_col_last;
        o_pix_last  = o_pix_eol && w_row_last;
        o_rom_addr  = (r_state == S_FETCH) ? w_fetch_addr : r_rom_addr;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_wait == '0) w_state_nxt = S_EMIT;
            S_EMIT:  if (w_accept && w_bit_last)
                         w_state_nxt = (w_col_last && w_row_last) ? S_DONE : S_FETCH;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_row      <= '0;
            r_col      <= '0;
            r_bit      <= '0;
            r_wait     <= '0;
            r_shift    <= '0;
            r_rom_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_row <= '0;
                    r_col <= '0;
                end
                S_FETCH: begin
                    r_rom_addr <= w_fetch_addr;
                    r_wait     <= WAIT_W'(ROM_LATENCY - 1);
                end
                S_WAIT: if (r_wait == '0) begin
                    r_shift <= i_rom_data;
                    r_bit   <= '0;
                end else begin
                    r_wait <= r_wait - WAIT_W'(1);
                end
                S_EMIT: if (w_accept) begin
                    r_shift <= r_shift << 1;
                    r_bit   <= r_bit + BIT_W'(1);
                    if (w_bit_last) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cursor    = r_cursor;
    assign o_cur_code  = r_cur_code;
    assign o_edit_wrap = r_edit_wrap;
endmodule

// File: tb/tb_text_overlay_writer.sv
// Bench for text_overlay_writer: two instances (ROM latency 1 and 3) share key/start/reset
// stimulus; pixels are checked against a string/font reference model.

module tb_text_overlay_writer;
    localparam int NC     = 8;
    localparam int GW     = 8;
    localparam int GH     = 16;
    localparam int ROWPIX = NC * GW;
    localparam int TOTAL  = ROWPIX * GH;

    logic clk = 1'b0, rst = 1'b1, kn = 1'b1, ks = 1'b1, start = 1'b0, rdy1 = 1'b0, rdy3 = 1'b0;
    always #5 clk = ~clk;

    logic        busy1, v1, eol1, last1, wrap1, busy3, v3, eol3, last3, wrap3;
    logic [11:0] addr1, addr3;
    logic [7:0]  rd1, rd3, code1, code3;
    logic [23:0] pix1, pix3;
    logic [2:0]  cur1, cur3;

    text_overlay_writer #(.ROM_LATENCY(1)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_key_next_n(kn), .i_key_sel_n(ks), .i_start(start),
        .o_busy(busy1), .o_rom_addr(addr1), .i_rom_data(rd1), .o_pix_data(pix1),
        .o_pix_valid(v1), .i_pix_ready(rdy1), .o_pix_eol(eol1), .o_pix_last(last1),
        .o_cursor(cur1), .o_cur_code(code1), .o_edit_wrap(wrap1));

    text_overlay_writer #(.ROM_LATENCY(3)) u_dut3 (
        .i_clock(clk), .i_reset(rst), .i_key_next_n(kn), .i_key_sel_n(ks), .i_start(start),
        .o_busy(busy3), .o_rom_addr(addr3), .i_rom_data(rd3), .o_pix_data(pix3),
        .o_pix_valid(v3), .i_pix_ready(rdy3), .o_pix_eol(eol3), .o_pix_last(last3),
        .o_cursor(cur3), .o_cur_code(code3), .o_edit_wrap(wrap3));

    function automatic logic [7:0] font(input logic [7:0] c, input logic [3:0] r);
        if (c == 8'h41 && r == 4'd0) return 8'h18;
        return (c * 8'd37) ^ ({4'h0, r} * 8'd91) ^ 8'h5A;
    endfunction

    // font ROM models with 1- and 3-cycle read latency
    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= font(addr1[11:4], addr1[3:0]);
        pipe3[0] <= font(addr3[11:4], addr3[3:0]);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rd1 = pipe1;
    assign rd3 = pipe3[2];

    int wraps1 = 0, wraps3 = 0;
    always @(negedge clk) begin
        if (wrap1 === 1'b1) wraps1++;
        if (wrap3 === 1'b1) wraps3++;
    end

    int         checks = 0, errors = 0;
    logic [7:0] mbuf [NC];
    int         mcur, mwraps;
    logic [7:0] mcode;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NC; i++) mbuf[i] = 8'h20;
        mcur  = 0;
        mcode = 8'h20;
    endtask

    task automatic m_event(input bit nxt, input bit sel);
        if (sel) begin
            mbuf[mcur] = mcode;
            if (mcur == NC - 1) begin mcur = 0; mwraps++; end
            else mcur++;
        end
        if (nxt) mcode = (mcode == 8'h7E) ? 8'h20 : mcode + 8'd1;
    endtask

    task automatic press(input bit nxt, input bit sel);
        @(posedge clk); #1;
        if (nxt) kn = 1'b0;
        if (sel) ks = 1'b0;
        repeat (30) @(posedge clk);
        #1 kn = 1'b1; ks = 1'b1;
        repeat (30) @(posedge clk);
        m_event(nxt, sel);
    endtask

    task automatic chk_edit(input string tag);
        @(negedge clk);
        chk({tag, "_code1"}, 64'(code1), 64'(mcode));
        chk({tag, "_cursor1"}, 64'(cur1), 64'(mcur));
        chk({tag, "_code3"}, 64'(code3), 64'(mcode));
        chk({tag, "_cursor3"}, 64'(cur3), 64'(mcur));
        chk({tag, "_wraps1"}, 64'(wraps1), 64'(mwraps));
        chk({tag, "_wraps3"}, 64'(wraps3), 64'(mwraps));
    endtask

    function automatic logic [25:0] exp_pix(input int n);
        int row, x, ch, b;
        logic [7:0] g;
        row = n / ROWPIX;
        x   = n % ROWPIX;
        ch  = x / GW;
        b   = x % GW;
        g   = font(mbuf[ch], row[3:0]);
        return {(g[GW-1-b] ? 24'hFFFFFF : 24'h000000), (x == ROWPIX - 1), (n == TOTAL - 1)};
    endfunction

    task automatic render(input bit rnd1, input int abort_at, input int dup_start_at);
        int n1, n3, cyc, ne1, ne3, nl1, nl3;
        logic [26:0] hold1, hold3;
        bit st1, st3;
        n1 = 0; n3 = 0; cyc = 0; ne1 = 0; ne3 = 0; nl1 = 0; nl3 = 0;
        st1 = 0; st3 = 0; hold1 = '0; hold3 = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start1", 64'(busy1), 64'(1));
        chk("busy_after_start3", 64'(busy3), 64'(1));
        while ((n1 < TOTAL || n3 < TOTAL) && cyc < 30000) begin
            rdy1  = rnd1 ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy3  = 1'($urandom_range(0, 1));
            start = (dup_start_at >= 0 && n1 == dup_start_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (st1) chk("stall_hold1", 64'({v1, eol1, last1, pix1}), 64'(hold1));
            if (st3) chk("stall_hold3", 64'({v3, eol3, last3, pix3}), 64'(hold3));
            st1 = 0; st3 = 0;
            if (v1 && n1 >= TOTAL) chk("extra_pix1", 64'(v1), 64'(0));
            else if (v1 && rdy1) begin
                chk("pix1", 64'({pix1, eol1, last1}), 64'(exp_pix(n1)));
                ne1 += int'(eol1); nl1 += int'(last1); n1++;
            end else if (v1) begin st1 = 1; hold1 = {v1, eol1, last1, pix1}; end
            if (v3 && n3 >= TOTAL) chk("extra_pix3", 64'(v3), 64'(0));
            else if (v3 && rdy3) begin
                chk("pix3", 64'({pix3, eol3, last3}), 64'(exp_pix(n3)));
                ne3 += int'(eol3); nl3 += int'(last3); n3++;
            end else if (v3) begin st3 = 1; hold3 = {v3, eol3, last3, pix3}; end
            if (abort_at >= 0 && n1 == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("abort_busy1", 64'(busy1), 64'(0));
                chk("abort_valid1", 64'(v1), 64'(0));
                chk("abort_busy3", 64'(busy3), 64'(0));
                chk("abort_valid3", 64'(v3), 64'(0));
                chk("abort_pix1", 64'(pix1), 64'(0));
                chk("abort_addr1", 64'(addr1), 64'(0));
                rst = 1'b0;
                start = 1'b0;
                m_reset();
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("frame_pixels1", 64'(n1), 64'(TOTAL));
        chk("frame_pixels3", 64'(n3), 64'(TOTAL));
        chk("frame_eol1", 64'(ne1), 64'(GH));
        chk("frame_eol3", 64'(ne3), 64'(GH));
        chk("frame_last1", 64'(nl1), 64'(1));
        chk("frame_last3", 64'(nl3), 64'(1));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_busy1", 64'(busy1), 64'(0));
        chk("idle_busy3", 64'(busy3), 64'(0));
        chk("idle_valid1", 64'(v1), 64'(0));
        chk("idle_valid3", 64'(v3), 64'(0));
    endtask

    initial begin
        m_reset();
        mwraps = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy1), 64'(0));
        chk("rst_valid", 64'(v1), 64'(0));
        chk("rst_eol_last", 64'({eol1, last1}), 64'(0));
        chk("rst_pix", 64'(pix1), 64'(0));
        chk("rst_addr", 64'(addr1), 64'(0));
        chk("rst_wrap", 64'(wrap1), 64'(0));
        rst = 1'b0;
        chk_edit("rst");

        repeat (3) press(1, 0);
        chk_edit("three_next");

        @(posedge clk); #1 kn = 1'b0;
        repeat (1000) @(posedge clk);
        #1 kn = 1'b1;
        repeat (40) @(posedge clk);
        m_event(1, 0);
        chk_edit("hold");

        for (int g = 0; g < 4; g++) begin
            @(posedge clk); #1 kn = 1'b0; ks = 1'b0;
            repeat (4 + 2 * g) @(posedge clk);
            #1 kn = 1'b1; ks = 1'b1;
            repeat (30) @(posedge clk);
        end
        chk_edit("glitch");

        while (mcode != 8'h7E) press(1, 0);
        chk_edit("at_max");
        press(1, 0);
        chk_edit("code_wrap");
        repeat (8) press(0, 1);
        chk_edit("sel8");

        repeat (33) press(1, 0);
        press(0, 1);
        for (int i = 1; i < NC - 1; i++) begin
            repeat ($urandom_range(1, 4)) press(1, 0);
            press(0, 1);
        end
        press(1, 1);
        chk_edit("string");

        render(1'b0, -1, -1);
        render(1'b1, -1, 500);
        render(1'b1, 300, -1);
        chk_edit("after_abort");
        render(1'b1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
